alu_writeback: RTL and testbench
================================

ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 Parameter: REG_ADDR_W, default 3, width of the destination register address.
REQ-002 Parameter: R0_HARDWIRED, default 1; when 1, writes to register 0 are suppressed.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: in_valid  input  1  execute stage presents an ALU result this cycle.
REQ-006 Port: in_opcode  input  4  opcode of the instruction, encoded per the shared opcode header.
REQ-007 Port: in_result  input  16  ALU result.
REQ-008 Port: in_zero / in_carry  input  1 each  ALU zero and carry_out.
REQ-009 Port: in_wen  input  1  instruction writes a destination register.
REQ-010 Port: in_rd  input  REG_ADDR_W  destination register address.
REQ-011 Port: stall  input  1  hold the writeback stage; no new entry accepted.
REQ-012 Port: flush  input  1  discard the incoming entry this cycle.
REQ-013 Port: rf_we / rf_waddr / rf_wdata  output  1 / REG_ADDR_W / 16  register-file write port.
REQ-014 Port: carry_flag / zero_flag  output  1 each  architectural flags; carry_flag drives the ALU carry_in.
REQ-015 Port: fwd_valid / fwd_rd / fwd_data  output  1 / REG_ADDR_W / 16  forwarding of the held entry to execute.
REQ-016 Port: retired  output  16  count of accepted entries.

Function
REQ-017 Accept: the entry is accepted at the edge ending cycle N iff in_valid & !stall & !flush.
REQ-018 On accept, hold register captures {wen, rd, result}; wb_valid=1; written=0.
REQ-019 Cycle N+1 after accept: rf_we=1 for exactly one cycle if wb_valid & wen & !written & !(R0_HARDWIRED & rd==0); rf_waddr=rd, rf_wdata=result.
REQ-020 After rf_we is asserted, written=1; no repeat write while the entry is held under stall.
REQ-021 With no accept in a cycle, wb_valid clears at the next edge unless stall=1, in which case the held entry and written bit are retained.
REQ-022 Flags update at the accepting edge (visible cycle N+1): zero_flag<=in_zero for every accepted opcode except the default/NOP encoding (no change).
REQ-023 carry_flag<=in_carry only for ADDC and SUBC; all other opcodes leave carry_flag unchanged.
REQ-024 Back-to-back ADDC in cycles N, N+1: second ALU operation sees carry_flag from the first (single-cycle flag latency).
REQ-025 fwd_valid = wb_valid & wen & !(R0_HARDWIRED & rd==0); fwd_rd=rd, fwd_data=result; stays valid while the entry is held.
REQ-026 flush has priority over in_valid; flush & stall together: input dropped, held entry retained.
REQ-027 flush never cancels an already held entry or its pending write.
REQ-028 retired increments by 1 per accept and saturates at 0xFFFF (no wrap).
REQ-029 All outputs are driven from registers or from register-only combinational logic; no combinational path from in_* to rf_*.

Reset
REQ-030 While rst=1 at an edge: wb_valid=0, written=0, carry_flag=0, zero_flag=0, retired=0, hold register cleared to 0.
REQ-031 While wb_valid=0: rf_we=0, fwd_valid=0, rf_waddr=0, rf_wdata=0, fwd_rd=0, fwd_data=0.
REQ-032 rst asserted mid-operation with a pending unwritten entry discards it; no rf_we in the cycle after reset.
REQ-033 rst has priority over stall, flush and in_valid.

Verification
REQ-034 ADDC result=0x0000, carry=1, zero=1, rd=2 -> next cycle rf_we=1, waddr=2, wdata=0x0000, carry_flag=1, zero_flag=1, retired=1.
REQ-035 XOR after REQ-034 with in_carry=0, result=0x00F0 -> carry_flag stays 1, zero_flag=0.
REQ-036 Accept rd=3 data 0x1234, then stall 3 cycles -> rf_we high only first cycle; fwd_valid=1, fwd_data=0x1234 all 4 cycles.
REQ-037 in_valid with flush=1, rd=4 data 0xBEEF -> no rf_we, flags and retired unchanged; with R0_HARDWIRED=1, rd=0 accept -> rf_we=0, fwd_valid=0, retired increments.
REQ-038 Preload retired to 0xFFFE via 2^16-2 accepts, 3 more accepts -> retired 0xFFFF and holds; rst mid-pending write -> all outputs 0 next cycle.

Source files
------------

// File: rtl/alu_writeback.sv
// alu_writeback: single-entry writeback stage with RF write, flag update, forwarding and retire count
module alu_writeback #(
  parameter int REG_ADDR_W   = 3,
  parameter int R0_HARDWIRED = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [3:0]            in_opcode,
  input  logic [15:0]           in_result,
  input  logic                  in_zero,
  input  logic                  in_carry,
  input  logic                  in_wen,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [15:0]           rf_wdata,
  output logic                  carry_flag,
  output logic                  zero_flag,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [15:0]           fwd_data,
  output logic [15:0]           retired
);
  // Opcodes 1..10 are real ALU operations; 0 and 11..15 behave as NOP
  localparam logic [3:0] OP_ADDC = 4'd2;
  localparam logic [3:0] OP_SUBC = 4'd4;
  localparam logic [3:0] OP_LAST = 4'd10;
  logic                  wb_valid_q, wb_valid_d;
  logic                  written_q, written_d;
  logic                  wen_q, wen_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [15:0]           result_q, result_d;
  logic                  carry_q, carry_d;
  logic                  zero_q, zero_d;
  logic [15:0]           retired_q, retired_d;
  logic                  accept;
  logic                  wr_ok;
  always_comb begin
    accept     = in_valid & ~stall & ~flush;
    wr_ok      = wb_valid_q & wen_q & ~((R0_HARDWIRED != 0) && (rd_q == '0));
    rf_we      = wr_ok & ~written_q;
    rf_waddr   = wb_valid_q ? rd_q : '0;
    rf_wdata   = wb_valid_q ? result_q : 16'h0000;
    fwd_valid  = wr_ok;
    fwd_rd     = rf_waddr;
    fwd_data   = rf_wdata;
    carry_flag = carry_q;
    zero_flag  = zero_q;
    retired    = retired_q;
    wb_valid_d = accept | (wb_valid_q & stall);
    written_d  = accept ? 1'b0 : (written_q | rf_we);
    wen_d      = accept ? in_wen : wen_q;
    rd_d       = accept ? in_rd : rd_q;
    result_d   = accept ? in_result : result_q;
    zero_d     = (accept && in_opcode != 4'd0 && in_opcode <= OP_LAST) ? in_zero : zero_q;
    carry_d    = (accept && (in_opcode == OP_ADDC || in_opcode == OP_SUBC)) ? in_carry : carry_q;
    retired_d  = (accept && retired_q != 16'hFFFF) ? retired_q + 16'd1 : retired_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      written_q  <= 1'b0;
      wen_q      <= 1'b0;
      rd_q       <= '0;
      result_q   <= 16'h0000;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      retired_q  <= 16'h0000;
    end else begin
      wb_valid_q <= wb_valid_d;
      written_q  <= written_d;
      wen_q      <= wen_d;
      rd_q       <= rd_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      retired_q  <= retired_d;
    end
  end
endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: directed and random checks of alu_writeback against an entry-level model
module tb_alu_writeback;
  localparam int AW = 3;
  localparam logic [3:0] NOP = 4'd0, ADDC = 4'd2, SUBC = 4'd4, XOR = 4'd7;
  logic clk = 1'b0;
  logic rst, in_valid, in_zero, in_carry, in_wen, stall, flush;
  logic [3:0] in_opcode;
  logic [15:0] in_result;
  logic [AW-1:0] in_rd;
  logic rf_we, carry_flag, zero_flag, fwd_valid;
  logic [AW-1:0] rf_waddr, fwd_rd;
  logic [15:0] rf_wdata, fwd_data, retired;
  int total = 0, bad = 0;
  bit m_valid, m_fresh, m_wen, m_c, m_z;
  int m_rd, m_res, m_ret;

  alu_writeback #(.REG_ADDR_W(AW), .R0_HARDWIRED(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_opcode(in_opcode),
    .in_result(in_result), .in_zero(in_zero), .in_carry(in_carry),
    .in_wen(in_wen), .in_rd(in_rd), .stall(stall), .flush(flush),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .carry_flag(carry_flag), .zero_flag(zero_flag), .fwd_valid(fwd_valid),
    .fwd_rd(fwd_rd), .fwd_data(fwd_data), .retired(retired));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // An entry is written exactly in the cycle after it was accepted, and stays visible while stalled
  task automatic check_model();
    bit wr_ok;
    wr_ok = m_valid && m_wen && m_rd != 0;
    chk("rf_we", rf_we, m_fresh && wr_ok);
    chk("rf_waddr", rf_waddr, m_valid ? m_rd : 0);
    chk("rf_wdata", rf_wdata, m_valid ? m_res : 0);
    chk("fwd_valid", fwd_valid, wr_ok);
    chk("fwd_rd", fwd_rd, m_valid ? m_rd : 0);
    chk("fwd_data", fwd_data, m_valid ? m_res : 0);
    chk("carry_flag", carry_flag, m_c);
    chk("zero_flag", zero_flag, m_z);
    chk("retired", retired, m_ret);
  endtask

  task automatic cyc(input bit v, input logic [3:0] op, input logic [15:0] res, input bit c,
                     input bit z, input bit w, input int rd, input bit st, input bit fl, input bit r);
    bit acc;
    rst = r; in_valid = v; in_opcode = op; in_result = res; in_carry = c;
    in_zero = z; in_wen = w; in_rd = AW'(rd); stall = st; flush = fl;
    @(posedge clk);
    acc = v && !st && !fl;
    if (r) begin
      m_valid = 0; m_fresh = 0; m_wen = 0; m_rd = 0; m_res = 0; m_c = 0; m_z = 0; m_ret = 0;
    end else if (acc) begin
      m_valid = 1; m_fresh = 1; m_wen = w; m_rd = rd; m_res = res;
      if (op >= 1 && op <= 10) m_z = z;
      if (op == ADDC || op == SUBC) m_c = c;
      if (m_ret < 65535) m_ret++;
    end else begin
      m_fresh = 0;
      m_valid = m_valid && st;
    end
    #1;
    check_model();
  endtask

  initial begin
    cyc(0, NOP, 16'h0, 0, 0, 0, 0, 0, 0, 1);
    chk("reset_retired", retired, 0);
    chk("reset_fwd", fwd_valid, 0);
    // ADDC producing zero with carry out into r2
    cyc(1, ADDC, 16'h0000, 1, 1, 1, 2, 0, 0, 0);
    chk("addc_we", rf_we, 1);
    chk("addc_waddr", rf_waddr, 2);
    chk("addc_carry", carry_flag, 1);
    chk("addc_zero", zero_flag, 1);
    chk("addc_retired", retired, 1);
    cyc(1, XOR, 16'h00F0, 0, 0, 1, 1, 0, 0, 0);
    chk("xor_carry", carry_flag, 1);
    chk("xor_zero", zero_flag, 0);
    cyc(1, ADDC, 16'h0001, 0, 0, 1, 1, 0, 0, 0);
    chk("addc2_carry", carry_flag, 0);
    // Accept then stall three cycles: one write, four cycles of forwarding
    cyc(1, ADDC, 16'h1234, 0, 0, 1, 3, 0, 0, 0);
    chk("stall0_we", rf_we, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, ADDC, 16'hAAAA, 1, 1, 1, 5, 1, 0, 0);
      chk("stall_we", rf_we, 0);
      chk("stall_fwd", fwd_data, 16'h1234);
    end
    cyc(0, NOP, 16'h0, 0, 0, 0, 0, 0, 0, 0);
    chk("post_stall_fwd", fwd_valid, 0);
    cyc(1, XOR, 16'hBEEF, 1, 1, 1, 4, 0, 1, 0);
    chk("flush_we", rf_we, 0);
    cyc(1, XOR, 16'h5555, 0, 1, 1, 0, 0, 0, 0);
    chk("r0_we", rf_we, 0);
    chk("r0_fwd", fwd_valid, 0);
    // flush while stalled keeps the held entry
    cyc(1, XOR, 16'h7777, 0, 0, 1, 6, 0, 0, 0);
    cyc(1, XOR, 16'h1111, 0, 0, 1, 1, 1, 1, 0);
    chk("flush_stall_fwd", fwd_data, 16'h7777);
    for (int i = 0; i < 500; i++)
      cyc($urandom_range(0, 9) < 7, 4'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom), $urandom_range(0, 7), $urandom_range(0, 3) == 0,
          $urandom_range(0, 6) == 0, $urandom_range(0, 49) == 0);
    cyc(0, NOP, 16'h0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 65534; i++) cyc(1, XOR, 16'(i), 0, 0, 1, 1, 0, 0, 0);
    chk("preload", retired, 16'hFFFE);
    for (int i = 0; i < 3; i++) cyc(1, XOR, 16'h1, 0, 0, 1, 1, 0, 0, 0);
    chk("saturate", retired, 16'hFFFF);
    cyc(1, SUBC, 16'h4321, 1, 0, 1, 5, 1, 0, 0);
    cyc(1, SUBC, 16'h4321, 1, 0, 1, 5, 0, 0, 0);
    cyc(1, XOR, 16'h9999, 1, 1, 1, 6, 0, 0, 1);
    chk("rst_we", rf_we, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_carry", carry_flag, 0);
    chk("rst_retired", retired, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
